dma_prio_arbiter: RTL and testbench

- Parametrised channel arbiter for the DMA controller. Replaces the fixed 4-channel priority logic.
- Synchronises the DREQ pins and merges them with software requests and the mask bits.
- Picks a winner by fixed or rotating priority, runs the HRQ/HLDA bus-hold handshake, and drives DACK for the granted channel until the transfer engine reports service complete.
- Sits between the register block (command/mask/request fields) and the transfer timing FSM.

---
 rtl/dma_pkg.sv | 40 ++++
 rtl/dma_prio_arbiter_if.sv | 32 +++
 rtl/dma_prio_arbiter_chk.sv | 25 ++
 rtl/dma_req_sync.sv | 28 ++
 rtl/dma_prio_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dma_prio_arbiter.sv | 229 ++++++++++++++++++++++
 6 files changed

// File: rtl/dma_pkg.sv
// Shared types, constants and the wrapped priority search used by the DMA channel arbiter.
package dma_pkg;

  localparam int MAX_CH          = 8;
  localparam int MAX_CH_W        = 3;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    GRANT = 2'd2
  } dma_arb_state_e;

  typedef struct packed {
    logic                vld;
    logic [MAX_CH_W-1:0] idx;
  } dma_pick_t;

  // First set bit of req at or after ptr, wrapping modulo num_ch.
  function automatic dma_pick_t rot_pick(input logic [MAX_CH-1:0]   req,
                                         input logic [MAX_CH_W-1:0] ptr,
                                         input int                  num_ch);
    dma_pick_t pick;
    int        idx;
    pick.vld = 1'b0;
    pick.idx = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= num_ch) begin
        idx = idx - num_ch;
      end
      if ((i < num_ch) && !pick.vld && req[idx[MAX_CH_W-1:0]]) begin
        pick.vld = 1'b1;
        pick.idx = idx[MAX_CH_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dma_prio_arbiter_if.sv
// Command/request/acknowledge bundle between the DMA register block, the CPU hold logic and the arbiter.
interface dma_prio_arbiter_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic              dreq_act_low;
  logic              dack_act_low;
  logic              rot_prio;
  logic              ctrl_dis;
  logic [NUM_CH-1:0] dreq;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] sw_req;
  logic              hlda;
  logic              svc_done;
  logic              hrq;
  logic [NUM_CH-1:0] dack;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_ch;
  logic [NUM_CH-1:0] sw_clr;

  modport master (
    output dreq_act_low, dack_act_low, rot_prio, ctrl_dis, dreq, mask, sw_req, hlda, svc_done,
    input  hrq, dack, grant_vld, grant_ch, sw_clr
  );

  modport slave (
    input  dreq_act_low, dack_act_low, rot_prio, ctrl_dis, dreq, mask, sw_req, hlda, svc_done,
    output hrq, dack, grant_vld, grant_ch, sw_clr
  );

endinterface

// File: rtl/dma_prio_arbiter_chk.sv
// Structural invariants of the arbiter outputs: single acknowledge, grant implies hold request.
module dma_prio_arbiter_chk #(
  parameter int NUM_CH = 4
) (
  input logic              i_clk,
  input logic              i_rst_n,
  input logic              i_hrq,
  input logic              i_grant_vld,
  input logic              i_dack_act_low,
  input logic [NUM_CH-1:0] i_dack
);

  logic [NUM_CH-1:0] w_ack;
  assign w_ack = i_dack ^ {NUM_CH{i_dack_act_low}};

  a_ack_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(w_ack))
    else $error("more than one DACK active");

  a_grant_hrq: assert property (@(posedge i_clk) disable iff (!i_rst_n) i_grant_vld |-> i_hrq)
    else $error("grant without HRQ");

  a_no_grant_no_ack: assert property (@(posedge i_clk) disable iff (!i_rst_n) !i_grant_vld |-> (w_ack == '0))
    else $error("DACK active without grant");

endmodule

// File: rtl/dma_req_sync.sv
// Per-bit multi-flop synchroniser for asynchronous DMA request/EOP pins.
module dma_req_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;

  // Shift chain: stage 0 samples the pin, last stage feeds the logic.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/dma_prio_arbiter.sv
// DMA channel arbiter: qualifies DREQ/software requests, picks a channel by fixed or
// rotating priority, runs the HRQ/HLDA hold handshake and drives DACK until service completes.
module dma_prio_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  dma_prio_arbiter_if.slave  bus
);

  localparam int CH_W = $clog2(NUM_CH);

  if ((NUM_CH < 2) || (NUM_CH > MAX_CH)) begin : g_bad_num_ch
    $error("dma_prio_arbiter: NUM_CH must be 2..8");
  end
  if ((SYNC_STAGES < 1) || (SYNC_STAGES > 3)) begin : g_bad_sync
    $error("dma_prio_arbiter: SYNC_STAGES must be 1..3");
  end

  dma_arb_state_e    r_state;
  dma_arb_state_e    w_state_nxt;
  logic              r_hrq;
  logic              w_hrq_nxt;
  logic              r_grant_vld;
  logic              w_grant_vld_nxt;
  logic [CH_W-1:0]   r_grant_ch;
  logic [CH_W-1:0]   w_grant_ch_nxt;
  logic [NUM_CH-1:0] r_ack;
  logic [NUM_CH-1:0] w_ack_nxt;
  logic [NUM_CH-1:0] r_sw_clr;
  logic [NUM_CH-1:0] w_sw_clr_nxt;
  logic [CH_W-1:0]   r_ptr;
  logic [CH_W-1:0]   w_ptr_nxt;

  logic [NUM_CH-1:0]   w_dreq_sync;
  logic [NUM_CH-1:0]   w_hw_req;
  logic [NUM_CH-1:0]   w_req;
  logic [NUM_CH-1:0]   w_req_after;
  logic [NUM_CH-1:0]   w_gnt_oh;
  logic [NUM_CH-1:0]   w_win_oh;
  logic [MAX_CH-1:0]   w_req_ext;
  logic [MAX_CH_W-1:0] w_ptr_ext;
  dma_pick_t           w_pick;
  logic [CH_W-1:0]     w_win;

  dma_req_sync #(
    .WIDTH  (NUM_CH),
    .STAGES (SYNC_STAGES)
  ) u_dreq_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (bus.dreq),
    .o_q     (w_dreq_sync)
  );

  // Request qualification; w_req_after drops the software bit being cleared by this service.
  always_comb begin
    w_hw_req = w_dreq_sync ^ {NUM_CH{bus.dreq_act_low}};
    w_gnt_oh = NUM_CH'(1) << r_grant_ch;
    if (bus.ctrl_dis) begin
      w_req       = '0;
      w_req_after = '0;
    end else begin
      w_req       = (w_hw_req & ~bus.mask) | bus.sw_req;
      w_req_after = (w_hw_req & ~bus.mask) | (bus.sw_req & ~w_gnt_oh);
    end
  end

  // Winner selection; fixed priority is the rotating search anchored at channel 0.
  always_comb begin
    w_req_ext               = '0;
    w_req_ext[NUM_CH-1:0]   = w_req;
    w_ptr_ext               = '0;
    if (bus.rot_prio) begin
      w_ptr_ext[CH_W-1:0] = r_ptr;
    end else begin
      w_ptr_ext = '0;
    end
    w_pick   = rot_pick(w_req_ext, w_ptr_ext, NUM_CH);
    w_win    = CH_W'(w_pick.idx);
    w_win_oh = NUM_CH'(1) << w_win;
  end

  // Next-state and next-output logic of the hold/grant FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_hrq_nxt       = r_hrq;
    w_grant_vld_nxt = r_grant_vld;
    w_grant_ch_nxt  = r_grant_ch;
    w_ack_nxt       = r_ack;
    w_sw_clr_nxt    = '0;
    w_ptr_nxt       = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_pick.vld) begin
          w_state_nxt = REQ;
          w_hrq_nxt   = 1'b1;
        end else begin
          w_hrq_nxt   = 1'b0;
        end
      end
      REQ: begin
        if (!w_pick.vld) begin
          w_state_nxt = IDLE;
          w_hrq_nxt   = 1'b0;
        end else if (bus.hlda) begin
          w_state_nxt     = GRANT;
          w_grant_vld_nxt = 1'b1;
          w_grant_ch_nxt  = w_win;
          w_ack_nxt       = w_win_oh;
        end else begin
          w_state_nxt = REQ;
        end
      end
      GRANT: begin
        if (bus.svc_done) begin
          w_grant_vld_nxt = 1'b0;
          w_ack_nxt       = '0;
          if (r_grant_ch == CH_W'(NUM_CH - 1)) begin
            w_ptr_nxt = '0;
          end else begin
            w_ptr_nxt = r_grant_ch + CH_W'(1);
          end
          if (bus.sw_req[r_grant_ch]) begin
            w_sw_clr_nxt = w_gnt_oh;
          end else begin
            w_sw_clr_nxt = '0;
          end
          if (|w_req_after) begin
            w_state_nxt = REQ;
            w_hrq_nxt   = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_hrq_nxt   = 1'b0;
          end
        end else if (!bus.hlda) begin
          // CPU took the bus back: drop the grant but keep asking for it.
          w_state_nxt     = REQ;
          w_grant_vld_nxt = 1'b0;
          w_ack_nxt       = '0;
        end else begin
          w_state_nxt = GRANT;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_hrq_nxt       = 1'b0;
        w_grant_vld_nxt = 1'b0;
        w_grant_ch_nxt  = '0;
        w_ack_nxt       = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_hrq       <= 1'b0;
      r_grant_vld <= 1'b0;
      r_grant_ch  <= '0;
      r_ack       <= '0;
      r_sw_clr    <= '0;
      r_ptr       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hrq       <= w_hrq_nxt;
      r_grant_vld <= w_grant_vld_nxt;
      r_grant_ch  <= w_grant_ch_nxt;
      r_ack       <= w_ack_nxt;
      r_sw_clr    <= w_sw_clr_nxt;
      r_ptr       <= w_ptr_nxt;
    end
  end

  assign bus.hrq       = r_hrq;
  assign bus.grant_vld = r_grant_vld;
  assign bus.grant_ch  = r_grant_ch;
  assign bus.sw_clr    = r_sw_clr;
  assign bus.dack      = r_ack ^ {NUM_CH{bus.dack_act_low}};

endmodule

// File: tb/tb_dma_prio_arbiter.sv
// Directed bench for dma_prio_arbiter: 4-channel instance for most scenarios, 8-channel for rotation.
module tb_dma_prio_arbiter;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  dma_prio_arbiter_if #(.NUM_CH(4)) if4 ();
  dma_prio_arbiter_if #(.NUM_CH(8)) if8 ();

  dma_prio_arbiter #(.NUM_CH(4), .SYNC_STAGES(2)) u_dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(if4));
  dma_prio_arbiter #(.NUM_CH(8), .SYNC_STAGES(2)) u_dut8 (.i_clk(clk), .i_rst_n(rst_n), .bus(if8));

  dma_prio_arbiter_chk #(.NUM_CH(4)) u_chk4 (.i_clk(clk), .i_rst_n(rst_n), .i_hrq(if4.hrq),
    .i_grant_vld(if4.grant_vld), .i_dack_act_low(if4.dack_act_low), .i_dack(if4.dack));
  dma_prio_arbiter_chk #(.NUM_CH(8)) u_chk8 (.i_clk(clk), .i_rst_n(rst_n), .i_hrq(if8.hrq),
    .i_grant_vld(if8.grant_vld), .i_dack_act_low(if8.dack_act_low), .i_dack(if8.dack));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {if4.dreq_act_low, if4.dack_act_low, if4.rot_prio, if4.ctrl_dis, if4.hlda, if4.svc_done} = 6'b0;
    if4.dreq = 4'h0; if4.mask = 4'h0; if4.sw_req = 4'h0;
    {if8.dreq_act_low, if8.dack_act_low, if8.rot_prio, if8.ctrl_dis, if8.hlda, if8.svc_done} = 6'b0;
    if8.dreq = 8'h00; if8.mask = 8'h00; if8.sw_req = 8'h00;
    #2;
    checks++; if (if4.hrq !== 1'b0) begin errors++; $display("FAIL reset_hrq got=%0b exp=0", if4.hrq); end
    checks++; if (if4.grant_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%0b exp=0", if4.grant_vld); end
    checks++; if (if4.grant_ch !== 2'd0) begin errors++; $display("FAIL reset_ch got=%0d exp=0", if4.grant_ch); end
    checks++; if (if4.sw_clr !== 4'b0000) begin errors++; $display("FAIL reset_swclr got=%b exp=0000", if4.sw_clr); end
    checks++; if (if4.dack !== 4'b0000) begin errors++; $display("FAIL reset_dack_hi got=%b exp=0000", if4.dack); end
    if4.dack_act_low = 1'b1;
    #1;
    checks++; if (if4.dack !== 4'b1111) begin errors++; $display("FAIL reset_dack_lo got=%b exp=1111", if4.dack); end
    if4.dack_act_low = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fixed_prio();
    if4.dreq = 4'b1010;
    tick();
    checks++; if (if4.hrq !== 1'b0) begin errors++; $display("FAIL fix_hrq_e1 got=%0b exp=0", if4.hrq); end
    tick();
    checks++; if (if4.hrq !== 1'b0) begin errors++; $display("FAIL fix_hrq_e2 got=%0b exp=0", if4.hrq); end
    tick();
    checks++; if (if4.hrq !== 1'b1) begin errors++; $display("FAIL fix_hrq_e3 got=%0b exp=1", if4.hrq); end
    if4.hlda = 1'b1;
    tick();
    checks++; if (if4.grant_ch !== 2'd1 || if4.grant_vld !== 1'b1) begin errors++; $display("FAIL fix_grant1 got ch=%0d vld=%0b exp ch=1 vld=1", if4.grant_ch, if4.grant_vld); end
    checks++; if (if4.dack !== 4'b0010) begin errors++; $display("FAIL fix_dack1 got=%b exp=0010", if4.dack); end
    if4.dreq = 4'b1000;
    repeat (3) tick();
    checks++; if (if4.grant_ch !== 2'd1 || if4.dack !== 4'b0010) begin errors++; $display("FAIL fix_frozen got ch=%0d dack=%b exp ch=1 dack=0010", if4.grant_ch, if4.dack); end
    if4.svc_done = 1'b1;
    tick();
    if4.svc_done = 1'b0;
    checks++; if (if4.grant_vld !== 1'b0 || if4.hrq !== 1'b1) begin errors++; $display("FAIL fix_after_svc got vld=%0b hrq=%0b exp vld=0 hrq=1", if4.grant_vld, if4.hrq); end
    tick();
    checks++; if (if4.grant_ch !== 2'd3 || if4.dack !== 4'b1000) begin errors++; $display("FAIL fix_grant3 got ch=%0d dack=%b exp ch=3 dack=1000", if4.grant_ch, if4.dack); end
    if4.dreq = 4'b0000;
    repeat (3) tick();
    if4.svc_done = 1'b1;
    tick();
    if4.svc_done = 1'b0;
    if4.hlda = 1'b0;
    checks++; if (if4.hrq !== 1'b0 || if4.dack !== 4'b0000) begin errors++; $display("FAIL fix_idle got hrq=%0b dack=%b exp hrq=0 dack=0000", if4.hrq, if4.dack); end
  endtask

  task automatic test_rotating();
    int n;
    if8.rot_prio = 1'b1;
    if8.hlda = 1'b1;
    if8.dreq = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      n = 0;
      while (!if8.grant_vld && n < 10) begin
        tick();
        n++;
      end
      checks++; if (n >= 10 || if8.grant_ch !== 3'(k % 8)) begin errors++; $display("FAIL rot_order k=%0d got ch=%0d vld=%0b exp ch=%0d", k, if8.grant_ch, if8.grant_vld, k % 8); end
      if8.svc_done = 1'b1;
      tick();
      if8.svc_done = 1'b0;
    end
    if8.dreq = 8'h00;
    if8.hlda = 1'b0;
    repeat (4) tick();
    checks++; if (if8.hrq !== 1'b0) begin errors++; $display("FAIL rot_idle got hrq=%0b exp=0", if8.hrq); end
  endtask

  task automatic test_polarity_mask();
    if4.mask = 4'b1111;
    if4.dreq = 4'b1101;
    if4.dreq_act_low = 1'b1;
    if4.dack_act_low = 1'b1;
    repeat (3) tick();
    if4.mask = 4'b0010;
    repeat (2) tick();
    checks++; if (if4.hrq !== 1'b0) begin errors++; $display("FAIL pol_masked_hrq got=%0b exp=0", if4.hrq); end
    checks++; if (if4.dack !== 4'b1111) begin errors++; $display("FAIL pol_idle_dack got=%b exp=1111", if4.dack); end
    if4.mask = 4'b0000;
    tick();
    checks++; if (if4.hrq !== 1'b1) begin errors++; $display("FAIL pol_unmask_hrq got=%0b exp=1", if4.hrq); end
    if4.hlda = 1'b1;
    tick();
    checks++; if (if4.grant_ch !== 2'd1 || if4.dack !== 4'b1101) begin errors++; $display("FAIL pol_grant got ch=%0d dack=%b exp ch=1 dack=1101", if4.grant_ch, if4.dack); end
    if4.hlda = 1'b0;
    if4.dreq = 4'b1111;
    repeat (5) tick();
    checks++; if (if4.hrq !== 1'b0 || if4.dack !== 4'b1111) begin errors++; $display("FAIL pol_release got hrq=%0b dack=%b exp hrq=0 dack=1111", if4.hrq, if4.dack); end
    if4.mask = 4'b1111;
    if4.dreq = 4'b0000;
    if4.dreq_act_low = 1'b0;
    if4.dack_act_low = 1'b0;
    repeat (3) tick();
    if4.mask = 4'b0000;
  endtask

  task automatic test_sw_req();
    if4.mask = 4'b1111;
    if4.sw_req = 4'b0100;
    tick();
    checks++; if (if4.hrq !== 1'b1) begin errors++; $display("FAIL sw_hrq got=%0b exp=1", if4.hrq); end
    if4.hlda = 1'b1;
    tick();
    checks++; if (if4.grant_ch !== 2'd2 || if4.dack !== 4'b0100) begin errors++; $display("FAIL sw_grant got ch=%0d dack=%b exp ch=2 dack=0100", if4.grant_ch, if4.dack); end
    if4.svc_done = 1'b1;
    tick();
    if4.svc_done = 1'b0;
    checks++; if (if4.sw_clr !== 4'b0100) begin errors++; $display("FAIL sw_clr_pulse got=%b exp=0100", if4.sw_clr); end
    checks++; if (if4.hrq !== 1'b0) begin errors++; $display("FAIL sw_hrq_drop got=%0b exp=0", if4.hrq); end
    if4.sw_req = 4'b0000;
    tick();
    checks++; if (if4.sw_clr !== 4'b0000 || if4.hrq !== 1'b0) begin errors++; $display("FAIL sw_clr_once got clr=%b hrq=%0b exp clr=0000 hrq=0", if4.sw_clr, if4.hrq); end
    if4.hlda = 1'b0;
    if4.mask = 4'b0000;
  endtask

  task automatic test_abort();
    if4.rot_prio = 1'b1;
    if4.dreq = 4'b1001;
    repeat (3) tick();
    if4.hlda = 1'b1;
    tick();
    checks++; if (if4.grant_ch !== 2'd3 || if4.grant_vld !== 1'b1) begin errors++; $display("FAIL abt_grant got ch=%0d vld=%0b exp ch=3 vld=1", if4.grant_ch, if4.grant_vld); end
    if4.hlda = 1'b0;
    tick();
    checks++; if (if4.dack !== 4'b0000 || if4.grant_vld !== 1'b0 || if4.hrq !== 1'b1) begin errors++; $display("FAIL abt_drop got dack=%b vld=%0b hrq=%0b exp dack=0000 vld=0 hrq=1", if4.dack, if4.grant_vld, if4.hrq); end
    checks++; if (if4.sw_clr !== 4'b0000) begin errors++; $display("FAIL abt_swclr got=%b exp=0000", if4.sw_clr); end
    if4.hlda = 1'b1;
    tick();
    checks++; if (if4.grant_ch !== 2'd3) begin errors++; $display("FAIL abt_ptr_kept got ch=%0d exp=3", if4.grant_ch); end
    if4.svc_done = 1'b1;
    tick();
    if4.svc_done = 1'b0;
    tick();
    checks++; if (if4.grant_ch !== 2'd0 || if4.dack !== 4'b0001) begin errors++; $display("FAIL abt_rotate got ch=%0d dack=%b exp ch=0 dack=0001", if4.grant_ch, if4.dack); end
    if4.dreq = 4'b0000;
    repeat (3) tick();
    if4.svc_done = 1'b1;
    tick();
    if4.svc_done = 1'b0;
    if4.hlda = 1'b0;
    if4.rot_prio = 1'b0;
    checks++; if (if4.hrq !== 1'b0) begin errors++; $display("FAIL abt_idle got hrq=%0b exp=0", if4.hrq); end
  endtask

  task automatic test_withdraw();
    if4.dreq = 4'b0100;
    repeat (3) tick();
    checks++; if (if4.hrq !== 1'b1) begin errors++; $display("FAIL wd_hrq got=%0b exp=1", if4.hrq); end
    if4.dreq = 4'b0000;
    repeat (2) tick();
    checks++; if (if4.hrq !== 1'b1) begin errors++; $display("FAIL wd_hold got=%0b exp=1", if4.hrq); end
    tick();
    checks++; if (if4.hrq !== 1'b0 || if4.grant_vld !== 1'b0) begin errors++; $display("FAIL wd_idle got hrq=%0b vld=%0b exp hrq=0 vld=0", if4.hrq, if4.grant_vld); end
  endtask

  task automatic test_async_reset();
    if4.sw_req = 4'b0001;
    tick();
    if4.hlda = 1'b1;
    tick();
    checks++; if (if4.dack !== 4'b0001) begin errors++; $display("FAIL ar_grant got dack=%b exp=0001", if4.dack); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (if4.hrq !== 1'b0 || if4.dack !== 4'b0000 || if4.grant_vld !== 1'b0) begin errors++; $display("FAIL ar_async got hrq=%0b dack=%b vld=%0b exp hrq=0 dack=0000 vld=0", if4.hrq, if4.dack, if4.grant_vld); end
    if4.sw_req = 4'b0000;
    if4.hlda = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    if4.ctrl_dis = 1'b1;
    if4.dreq = 4'b1111;
    repeat (4) tick();
    checks++; if (if4.hrq !== 1'b0) begin errors++; $display("FAIL ar_ctrl_dis got hrq=%0b exp=0", if4.hrq); end
    if4.ctrl_dis = 1'b0;
    tick();
    checks++; if (if4.hrq !== 1'b1) begin errors++; $display("FAIL ar_ctrl_en got hrq=%0b exp=1", if4.hrq); end
    if4.dreq = 4'b0000;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fixed_prio();
    test_rotating();
    test_polarity_mask();
    test_sw_req();
    test_abort();
    test_withdraw();
    test_async_reset();
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
